// File: rtl/nes_clk_en_gen.sv
// Master-clock divider producing CPU/PPU clock-enable strobes, staged core resets,
// a debug halt/single-step controller and a free-running CPU cycle counter.
module nes_clk_en_gen #(
    parameter int CPU_DIV  = 12,
    parameter int PPU_DIV  = 4,
    parameter int RST_HOLD = 8,
    parameter int CPU_LAG  = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk_mst,
    input  logic             rst_mst_n,
    input  logic             halt,
    input  logic             step,
    output logic             clk_en_cpu,
    output logic             clk_en_ppu,
    output logic             rst_en_cpu,
    output logic             rst_en_ppu,
    output logic             halted,
    output logic [CNT_W-1:0] cpu_cycle_cnt
);

    localparam int PH_W     = (CPU_DIV > 2) ? $clog2(CPU_DIV) : 1;
    localparam int TICK_MAX = RST_HOLD + CPU_LAG;
    localparam int TK_W     = $clog2(TICK_MAX + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CPU_DIV - 1);

    typedef enum logic [2:0] {
        RESET_SEQ,
        RUN,
        HALT_PEND,
        HALTED,
        STEP
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [TK_W-1:0] tick_q, tick_d;
    logic            run_q;
    logic            adv;
    logic            at_last;
    logic            seq_done;
    logic            ppu_d;
    logic            cpu_d;

    assign at_last = (phase_q == PH_LAST);

    // Reset tick counter only moves while the CPU is still held in reset.
    always_comb begin
        tick_d = tick_q;
        if (clk_en_cpu && rst_en_cpu) begin
            tick_d = tick_q + 1'b1;
        end
    end

    assign seq_done = rst_en_cpu && (tick_d == TK_W'(TICK_MAX));

    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        case (state_q)
            RESET_SEQ: begin
                adv = run_q;
                if (seq_done) state_d = RUN;
            end
            RUN: begin
                adv = 1'b1;
                if (halt) state_d = HALT_PEND;
            end
            HALT_PEND: begin
                adv = 1'b1;
                if (!halt)        state_d = RUN;
                else if (at_last) state_d = HALTED;
            end
            HALTED: begin
                // Release beats a simultaneous step; phase stays at 0 on exit.
                if (!halt)     state_d = RUN;
                else if (step) state_d = STEP;
            end
            STEP: begin
                adv = 1'b1;
                if (at_last) state_d = halt ? HALTED : RUN;
            end
            default: state_d = RESET_SEQ;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if (adv) begin
            phase_d = at_last ? '0 : phase_q + 1'b1;
        end
        ppu_d = ((int'(phase_d) % PPU_DIV) == (PPU_DIV - 1));
        cpu_d = (phase_d == PH_LAST);
    end

    always_ff @(posedge clk_mst or negedge rst_mst_n) begin
        if (!rst_mst_n) begin
            state_q <= RESET_SEQ;
            phase_q <= '0;
            tick_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk_mst or negedge rst_mst_n) begin
        if (!rst_mst_n) begin
            clk_en_cpu    <= 1'b0;
            clk_en_ppu    <= 1'b0;
            rst_en_cpu    <= 1'b1;
            rst_en_ppu    <= 1'b1;
            halted        <= 1'b0;
            cpu_cycle_cnt <= '0;
        end else begin
            clk_en_cpu <= cpu_d;
            clk_en_ppu <= ppu_d;
            halted     <= (state_d == HALTED);
            if (tick_d >= TK_W'(RST_HOLD)) rst_en_ppu <= 1'b0;
            if (seq_done) rst_en_cpu <= 1'b0;
            if (clk_en_cpu && !rst_en_cpu) begin
                cpu_cycle_cnt <= cpu_cycle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nes_clk_en_gen.sv
// Directed bench for nes_clk_en_gen: reset sequencing table, counter wrap,
// halt/step/release sequences and an asynchronous reset in the middle of a step.
module tb_nes_clk_en_gen;

    localparam int CPU_DIV = 12;
    localparam int PPU_DIV = 4;

    logic        clk_mst = 1'b0;
    logic        rst_mst_n;
    logic        halt;
    logic        step;
    logic        clk_en_cpu, clk_en_ppu, rst_en_cpu, rst_en_ppu, halted;
    logic [15:0] cpu_cycle_cnt;
    logic        w4_en_cpu, w4_en_ppu, w4_rst_cpu, w4_rst_ppu, w4_halted;
    logic [3:0]  w4_cnt;

    nes_clk_en_gen dut (
        .clk_mst(clk_mst), .rst_mst_n(rst_mst_n), .halt(halt), .step(step),
        .clk_en_cpu(clk_en_cpu), .clk_en_ppu(clk_en_ppu),
        .rst_en_cpu(rst_en_cpu), .rst_en_ppu(rst_en_ppu),
        .halted(halted), .cpu_cycle_cnt(cpu_cycle_cnt)
    );

    nes_clk_en_gen #(.CNT_W(4)) dut_w4 (
        .clk_mst(clk_mst), .rst_mst_n(rst_mst_n), .halt(halt), .step(step),
        .clk_en_cpu(w4_en_cpu), .clk_en_ppu(w4_en_ppu),
        .rst_en_cpu(w4_rst_cpu), .rst_en_ppu(w4_rst_ppu),
        .halted(w4_halted), .cpu_cycle_cnt(w4_cnt)
    );

    always #5 clk_mst = ~clk_mst;

    typedef struct {
        int   cyc;
        logic en_ppu;
        logic en_cpu;
        logic r_ppu;
        logic r_cpu;
        logic hlt;
        int   cnt;
    } vec_t;

    vec_t       tbl [9];
    logic [1:0] exp_q [$];
    int         cyc  = 0;
    int         nvec = 0;
    int         nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_mst);
        #1;
        cyc++;
    endtask

    // Free-running model: phase 0 was visible in cycle ph0.
    task automatic chk_en(input int ph0, input logic hexp);
        int p;
        p = (cyc - ph0) % CPU_DIV;
        chk("en_ppu", clk_en_ppu, ((p % PPU_DIV) == PPU_DIV - 1));
        chk("en_cpu", clk_en_cpu, (p == CPU_DIV - 1));
        chk("halted", halted, hexp);
    endtask

    task automatic run_to(input int target, input int ph0, input logic hexp);
        while (cyc < target) begin
            tick();
            chk_en(ph0, hexp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en_cpu"}, clk_en_cpu, 1'b0);
        chk({tag, "_en_ppu"}, clk_en_ppu, 1'b0);
        chk({tag, "_rst_cpu"}, rst_en_cpu, 1'b1);
        chk({tag, "_rst_ppu"}, rst_en_ppu, 1'b1);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_cnt"}, cpu_cycle_cnt, 0);
        chk({tag, "_cnt_w4"}, w4_cnt, 0);
    endtask

    // Edge 0 is the first rising edge that samples rst_mst_n high.
    task automatic release_rst();
        @(negedge clk_mst);
        rst_mst_n = 1'b1;
        @(posedge clk_mst);
        #1;
        cyc = 0;
        chk_en(0, 1'b0);
    endtask

    task automatic run_table();
        for (int i = 0; i < 9; i++) begin
            run_to(tbl[i].cyc, 0, 1'b0);
            chk("tbl_en_ppu", clk_en_ppu, tbl[i].en_ppu);
            chk("tbl_en_cpu", clk_en_cpu, tbl[i].en_cpu);
            chk("tbl_rst_ppu", rst_en_ppu, tbl[i].r_ppu);
            chk("tbl_rst_cpu", rst_en_cpu, tbl[i].r_cpu);
            chk("tbl_halted", halted, tbl[i].hlt);
            chk("tbl_cnt", cpu_cycle_cnt, tbl[i].cnt);
        end
    endtask

    initial begin
        int s, r, n_ppu, n_cpu;
        logic [1:0] e;

        tbl[0] = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[1] = '{3,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[2] = '{11,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[3] = '{15,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[4] = '{23,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[5] = '{95,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[6] = '{96,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[7] = '{119, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[8] = '{120, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        // Clock/reset
        rst_mst_n = 1'b1;
        halt      = 1'b0;
        step      = 1'b0;
        #2;
        rst_mst_n = 1'b0;
        #1;
        chk_reset_vals("por");
        repeat (3) @(posedge clk_mst);
        #1;
        chk_reset_vals("hold");

        // Reset release with defaults, then counter checks
        release_rst();
        run_table();
        run_to(131, 0, 1'b0);
        chk("cnt_first", cpu_cycle_cnt, 0);
        run_to(132, 0, 1'b0);
        chk("cnt_one", cpu_cycle_cnt, 1);
        run_to(324, 0, 1'b0);
        chk("cnt_17", cpu_cycle_cnt, 17);
        chk("cnt_w4_wrap", w4_cnt, 1);
        run_to(1320, 0, 1'b0);
        chk("cnt_100", cpu_cycle_cnt, 100);

        // Halt raised while phase 5 is visible; CPU cycle finishes first
        run_to(1325, 0, 1'b0);
        halt = 1'b1;
        run_to(1331, 0, 1'b0);
        tick();
        chk("halt_halted", halted, 1'b1);
        chk("halt_en_ppu", clk_en_ppu, 1'b0);
        chk("halt_en_cpu", clk_en_cpu, 1'b0);
        chk("halt_cnt", cpu_cycle_cnt, 101);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("frozen_ppu", clk_en_ppu, 1'b0);
            chk("frozen_cpu", clk_en_cpu, 1'b0);
            chk("frozen_halted", halted, 1'b1);
        end
        chk("frozen_cnt", cpu_cycle_cnt, 101);

        // Single step with a second step request dropped mid-step
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < CPU_DIV; i++) begin
            exp_q.push_back({((i % PPU_DIV) == PPU_DIV - 1), (i == CPU_DIV - 1)});
        end
        n_ppu = 0;
        n_cpu = 0;
        for (int i = 0; i < CPU_DIV; i++) begin
            e = exp_q.pop_front();
            chk("step_ppu", clk_en_ppu, e[1]);
            chk("step_cpu", clk_en_cpu, e[0]);
            chk("step_halted", halted, 1'b0);
            n_ppu += int'(clk_en_ppu);
            n_cpu += int'(clk_en_cpu);
            step = (i == 4);
            tick();
        end
        step = 1'b0;
        chk("step_n_ppu", n_ppu, 3);
        chk("step_n_cpu", n_cpu, 1);
        chk("step_rehalt", halted, 1'b1);
        chk("step_cnt", cpu_cycle_cnt, 102);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_step_ppu", clk_en_ppu, 1'b0);
            chk("post_step_cpu", clk_en_cpu, 1'b0);
            chk("post_step_halted", halted, 1'b1);
        end

        // Asynchronous reset between edges in the middle of a step
        step = 1'b1;
        tick();
        step = 1'b0;
        s = cyc;
        run_to(s + 5, s, 1'b0);
        #2;
        rst_mst_n = 1'b0;
        #1;
        chk_reset_vals("midstep");
        repeat (2) @(posedge clk_mst);
        #1;
        chk_reset_vals("midstep_hold");

        // Halt held through reset sequencing: ignored until rst_en_cpu releases
        release_rst();
        run_table();
        run_to(131, 0, 1'b0);
        chk("seqhalt_cnt0", cpu_cycle_cnt, 0);
        tick();
        chk("seqhalt_halted", halted, 1'b1);
        chk("seqhalt_en_ppu", clk_en_ppu, 1'b0);
        chk("seqhalt_en_cpu", clk_en_cpu, 1'b0);
        chk("seqhalt_cnt1", cpu_cycle_cnt, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("seqhalt_frozen_ppu", clk_en_ppu, 1'b0);
            chk("seqhalt_frozen_halted", halted, 1'b1);
        end

        // Release from HALTED: phase restarts at 0
        halt = 1'b0;
        tick();
        r = cyc;
        chk_en(r, 1'b0);
        run_to(r + 12, r, 1'b0);
        chk("release_cnt", cpu_cycle_cnt, 2);

        // Halt dropped during HALT_PEND: no gap in enables
        run_to(r + 14, r, 1'b0);
        halt = 1'b1;
        tick();
        chk_en(r, 1'b0);
        halt = 1'b0;
        run_to(r + 40, r, 1'b0);
        chk("pend_drop_cnt", cpu_cycle_cnt, 4);
        chk("pend_drop_rst_cpu", rst_en_cpu, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nes_clk_en_gen.md
Name: nes_clk_en_gen

Overview:
- Generates the CPU and PPU clock-enable strobes and the staged CPU/PPU reset enables from the master clock.
- Sits inside the user core, directly downstream of the master clock/reset source. Its strobes feed the CPU and PPU cores.
- Provides a debug halt/single-step facility and a free-running CPU cycle counter.

Parameters:
- CPU_DIV, 12, master cycles per CPU cycle. Must be a multiple of PPU_DIV and at least 2.
- PPU_DIV, 4, master cycles per PPU cycle. Must be at least 2.
- RST_HOLD, 8, number of clk_en_cpu pulses after reset release before rst_en_ppu deasserts. Must be at least 1.
- CPU_LAG, 2, additional clk_en_cpu pulses after rst_en_ppu deasserts before rst_en_cpu deasserts. Must be at least 1.
- CNT_W, 16, width of cpu_cycle_cnt.

Ports:
- clk_mst  in  1  master clock
- rst_mst_n  in  1  asynchronous active-low reset. Assertion is asynchronous, deassertion is sampled on clk_mst.
- halt  in  1  debug halt request, level-sensitive
- step  in  1  single-step request, one-cycle pulse, honoured only while halted
- clk_en_cpu  out  1  CPU clock enable, one master cycle wide
- clk_en_ppu  out  1  PPU clock enable, one master cycle wide
- rst_en_cpu  out  1  active-high CPU core reset
- rst_en_ppu  out  1  active-high PPU core reset
- halted  out  1  high while the generator is frozen
- cpu_cycle_cnt  out  CNT_W  count of clk_en_cpu pulses since rst_en_cpu released

Behaviour:
- Clock and reset: single clock domain, clk_mst. rst_mst_n is async active-low.
- Reset values (all asynchronous on rst_mst_n low):
  - phase = 0
  - clk_en_cpu = 0, clk_en_ppu = 0
  - rst_en_cpu = 1, rst_en_ppu = 1
  - halted = 0
  - cpu_cycle_cnt = 0
  - reset tick counter = 0
- Phase counter: counts 0..CPU_DIV-1 and wraps to 0. It advances every cycle while running.
- Enables: all outputs are registered and decoded from the phase value in the same cycle.
  - clk_en_ppu = 1 exactly when phase mod PPU_DIV == PPU_DIV-1.
  - clk_en_cpu = 1 exactly when phase == CPU_DIV-1.
  - With defaults, edge 0 is the first edge where rst_mst_n is sampled high. clk_en_ppu is then high in cycles 3, 7, 11, ... and clk_en_cpu in cycles 11, 23, ...
  - Every clk_en_cpu pulse coincides with a clk_en_ppu pulse.
- Reset sequencing:
  - A tick counter counts clk_en_cpu pulses after reset.
  - rst_en_ppu falls on the cycle after the RST_HOLD-th pulse.
  - rst_en_cpu falls on the cycle after the (RST_HOLD+CPU_LAG)-th pulse.
  - Once both are low they stay low until rst_mst_n asserts again.
  - halt and step are ignored until rst_en_cpu is low; enables free-run during sequencing.
- State machine with states RESET_SEQ, RUN, HALT_PEND, HALTED, STEP:
  - RESET_SEQ -> RUN when rst_en_cpu releases.
  - RUN: halt=1 -> HALT_PEND.
  - HALT_PEND: runs until phase == CPU_DIV-1 (a clk_en_cpu cycle), then -> HALTED, with phase wrapping to 0. A CPU cycle is never truncated.
  - HALTED: phase is frozen at 0, no enables, halted=1.
    - step=1 -> STEP.
    - halt=0 -> RUN. Phase resumes from 0.
    - If step and halt=0 occur simultaneously, release wins and step is dropped.
  - STEP: runs exactly CPU_DIV master cycles, producing CPU_DIV/PPU_DIV clk_en_ppu pulses and one clk_en_cpu pulse, then returns to HALTED.
    - Steps arriving during STEP are dropped.
    - If halt drops during STEP, the step completes and the FSM goes to RUN.
  - halted is high only in HALTED.
  - If halt drops during HALT_PEND, the FSM returns to RUN with no gap in enables.
- cpu_cycle_cnt: increments by 1 on every clk_en_cpu while rst_en_cpu is low. It wraps modulo 2^CNT_W with no saturation.
- Mid-operation reset: rst_mst_n low at any time immediately forces all outputs to their reset values. The sequence restarts from RESET_SEQ.

Test Plan:
- Reset release, defaults -> clk_en_ppu high in cycles 3, 7, 11, 15. clk_en_cpu high only in cycles 11, 23. rst_en_ppu falls at cycle 96 (after pulse 8 at cycle 95). rst_en_cpu falls at cycle 120.
- Run 100 CPU cycles after release -> cpu_cycle_cnt == 100. With CNT_W=4, 17 CPU cycles -> cpu_cycle_cnt == 1 (wrap).
- halt raised at phase 5 -> 6 more cycles of enables including clk_en_cpu at phase 11. halted=1 next cycle, then no enables for 50 cycles.
- While halted, pulse step -> exactly 3 clk_en_ppu and 1 clk_en_cpu over 12 cycles, cpu_cycle_cnt +1, halted returns to 1. A second step mid-STEP is ignored.
- halt asserted during RESET_SEQ -> ignored. Sequencing completes at cycle 120, then FSM enters HALT_PEND and halts at the next CPU boundary.
- rst_mst_n pulsed low mid-STEP (asynchronous, between edges) -> outputs reset within the same cycle: rst_en_* = 1, enables = 0, halted = 0, cpu_cycle_cnt = 0. Timing then matches scenario 1.
